// File: rtl/ieeedrv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ieeedrv_pkg
//  Description : Shared types and widths for the IEEE drive SD channel logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package ieeedrv_pkg;

    localparam int SD_LBA_W = 32;
    localparam int SD_BLK_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } sd_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ieeedrv_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ieeedrv_rr_pick
//  Description : Combinational round-robin priority encoder. Picks the first
//                pending requester scanning upward from the one after i_last,
//                wrapping modulo NBD.
//  Revision    : 1.0 - initial release
// ============================================================================
module ieeedrv_rr_pick #(
    parameter int NBD   = 2,
    parameter int IDX_W = 1
) (
    input  logic [NBD-1:0]   i_pending,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest pending index wins.
    always_comb begin
        o_grant = i_last;
        w_idx   = '0;
        for (int i = NBD; i >= 1; i--) begin
            w_idx = IDX_W'((int'(i_last) + i) % NBD);
            if (i_pending[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

    assign o_valid = |i_pending;

endmodule
`default_nettype wire

// File: rtl/ieeedrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ieeedrv_sd_arbiter
//  Description : Round-robin sharing of one hps_io SD block-device slot among
//                NBD drive sub-units. One transfer in flight; the host ack is
//                routed back only to the granted requester; a watchdog aborts
//                a strobe the host never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module ieeedrv_sd_arbiter
    import ieeedrv_pkg::*;
#(
    parameter int NBD   = 2,
    parameter int TMO_W = 24
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [NBD-1:0][SD_LBA_W-1:0]  req_lba,
    input  logic [NBD-1:0][SD_BLK_W-1:0]  req_blk_cnt,
    input  logic [NBD-1:0]                req_rd,
    input  logic [NBD-1:0]                req_wr,
    input  logic [NBD-1:0][7:0]           req_buff_din,
    output logic [NBD-1:0]                req_ack,
    output logic [SD_LBA_W-1:0]           sd_lba,
    output logic [SD_BLK_W-1:0]           sd_blk_cnt,
    output logic                          sd_rd,
    output logic                          sd_wr,
    input  logic                          sd_ack,
    output logic [7:0]                    sd_buff_din,
    output logic                          busy,
    output logic                          tmo
);

    localparam int                IDX_W       = (NBD > 1) ? $clog2(NBD) : 1;
    localparam logic [IDX_W-1:0]  c_last_rst  = IDX_W'(NBD - 1);
    // Abort fires on the update that would bring the counter to all-ones.
    localparam logic [TMO_W-1:0]  c_wdog_last = {{(TMO_W-1){1'b1}}, 1'b0};

    sd_arb_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_last,  w_last_nxt;
    logic [IDX_W-1:0]       r_grant, w_grant_nxt;
    logic [SD_LBA_W-1:0]    r_lba,   w_lba_nxt;
    logic [SD_BLK_W-1:0]    r_blk,   w_blk_nxt;
    logic                   r_rd,    w_rd_nxt;
    logic                   r_wr,    w_wr_nxt;
    logic                   r_tmo,   w_tmo_nxt;
    logic [TMO_W-1:0]       r_wdog,  w_wdog_nxt;

    logic [IDX_W-1:0]       w_pick;
    logic                   w_pick_valid;

    ieeedrv_rr_pick #(
        .NBD   (NBD),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_pending (req_rd | req_wr),
        .i_last    (r_last),
        .o_grant   (w_pick),
        .o_valid   (w_pick_valid)
    );

    // State and datapath registers; reset returns to IDLE with requester 0 first.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= c_last_rst;
            r_grant <= '0;
            r_lba   <= '0;
            r_blk   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_tmo   <= 1'b0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_lba   <= w_lba_nxt;
            r_blk   <= w_blk_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_tmo   <= w_tmo_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_lba_nxt   = r_lba;
        w_blk_nxt   = r_blk;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_tmo_nxt   = 1'b0;
        w_wdog_nxt  = '0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick;
                    w_lba_nxt   = req_lba[w_pick];
                    w_blk_nxt   = req_blk_cnt[w_pick];
                    // Read wins when a requester raises both strobes.
                    w_rd_nxt    = req_rd[w_pick];
                    w_wr_nxt    = ~req_rd[w_pick];
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_state_nxt = XFER;
                end else if (r_wdog == c_wdog_last) begin
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_tmo_nxt   = 1'b1;
                    w_last_nxt  = r_grant;
                    w_state_nxt = IDLE;
                end else begin
                    w_wdog_nxt  = r_wdog + 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_last_nxt  = r_grant;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Host ack is steered only to the granted requester while a transfer is open.
    always_comb begin
        req_ack = '0;
        if (r_state == ISSUE || r_state == XFER) begin
            req_ack[r_grant] = sd_ack;
        end
    end

    assign sd_lba      = r_lba;
    assign sd_blk_cnt  = r_blk;
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign tmo         = r_tmo;
    assign busy        = (r_state != IDLE);
    assign sd_buff_din = busy ? req_buff_din[r_grant] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ieeedrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ieeedrv_sd_arbiter
//  Description : Self-checking bench for ieeedrv_sd_arbiter. The bench plays
//                the host side and predicts each grant and its timing from a
//                transaction-level round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ieeedrv_sd_arbiter;

    localparam int NBD   = 2;
    localparam int TMO_W = 4;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic [NBD-1:0][31:0] req_lba      = '0;
    logic [NBD-1:0][5:0]  req_blk_cnt  = '0;
    logic [NBD-1:0]       req_rd       = '0;
    logic [NBD-1:0]       req_wr       = '0;
    logic [NBD-1:0][7:0]  req_buff_din = '0;
    logic [NBD-1:0]       req_ack;
    logic [31:0]          sd_lba;
    logic [5:0]           sd_blk_cnt;
    logic                 sd_rd, sd_wr;
    logic                 sd_ack = 1'b0;
    logic [7:0]           sd_buff_din;
    logic                 busy, tmo;

    int checks   = 0;
    int failures = 0;
    int m_last   = NBD - 1;

    ieeedrv_sd_arbiter #(.NBD(NBD), .TMO_W(TMO_W)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_lba      (req_lba),
        .req_blk_cnt  (req_blk_cnt),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_buff_din (req_buff_din),
        .req_ack      (req_ack),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy),
        .tmo          (tmo)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference round robin: first pending index after the last winner.
    function automatic int rr(input int last, input logic [NBD-1:0] pend);
        for (int i = 1; i <= NBD; i++) begin
            int idx;
            idx = (last + i) % NBD;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NBD-1:0] onehot(input int g);
        logic [NBD-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // One transaction starting in an IDLE cycle. ack_dly >= TMO_CYC means the
    // host never answers and the watchdog must fire.
    task automatic xfer(input int ack_dly, input int ack_len, input bit drop);
        logic [NBD-1:0] pend;
        int   g;
        logic e_rd;
        logic [31:0] e_lba;
        logic [5:0]  e_blk;
        logic [7:0]  e_din;
        pend = req_rd | req_wr;
        if (pend == '0) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_tmo", tmo, 0);
            return;
        end
        g     = rr(m_last, pend);
        e_rd  = req_rd[g];
        e_lba = req_lba[g];
        e_blk = req_blk_cnt[g];
        e_din = req_buff_din[g];
        step();
        check("issue_rd", sd_rd, e_rd);
        check("issue_wr", sd_wr, !e_rd);
        check("issue_lba", sd_lba, e_lba);
        check("issue_blk", sd_blk_cnt, e_blk);
        check("issue_busy", busy, 1);
        check("issue_din", sd_buff_din, e_din);
        for (int j = 0; j < TMO_CYC; j++) begin
            if (j == ack_dly) break;
            check("issue_noack", req_ack, 0);
            step();
            if (j + 1 == TMO_CYC) begin
                check("tmo_pulse", tmo, 1);
                check("tmo_rd", sd_rd, 0);
                check("tmo_wr", sd_wr, 0);
                check("tmo_busy", busy, 0);
                m_last = g;
                return;
            end
            check("issue_hold", {sd_rd, sd_wr}, {e_rd, !e_rd});
            check("issue_tmo0", tmo, 0);
        end
        sd_ack = 1'b1;
        #1;
        check("ack_rise", req_ack, onehot(g));
        if (drop) begin
            req_rd[g] = 1'b0;
            req_wr[g] = 1'b0;
        end
        for (int k = 1; k <= ack_len; k++) begin
            step();
            check("xfer_strobe", {sd_rd, sd_wr}, 0);
            check("xfer_busy", busy, 1);
            check("xfer_din", sd_buff_din, e_din);
            if (k < ack_len) check("xfer_ack", req_ack, onehot(g));
            else sd_ack = 1'b0;
        end
        #1;
        check("ack_fall", req_ack, 0);
        step();
        check("done_busy", busy, 1);
        check("done_din", sd_buff_din, e_din);
        step();
        check("end_busy", busy, 0);
        check("end_lba_hold", sd_lba, e_lba);
        m_last = g;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int g;
        req_buff_din[0] = 8'h5A;
        req_buff_din[1] = 8'hC3;
        req_lba[0]      = 32'hDEAD_0000;
        step();
        step();
        check("rst_lba", sd_lba, 0);
        check("rst_blk", sd_blk_cnt, 0);
        check("rst_rd", sd_rd, 0);
        check("rst_wr", sd_wr, 0);
        check("rst_ack", req_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", tmo, 0);
        check("rst_din", sd_buff_din, 0);
        reset = 1'b0;

        // Single read from requester 1.
        req_lba[1] = 32'h123;
        req_blk_cnt[1] = 6'd3;
        req_rd = 2'b10;
        xfer(2, 5, 1'b1);

        // Fairness: both requesting continuously.
        req_lba[0] = 32'hAAAA;
        req_lba[1] = 32'hBBBB;
        req_rd = 2'b11;
        for (int n = 0; n < 4; n++) xfer(n, 2, 1'b0);
        req_rd = '0;
        step();

        // Write data routing.
        req_buff_din[0] = 8'hA5;
        req_buff_din[1] = 8'h3C;
        req_wr = 2'b01;
        xfer(1, 3, 1'b1);

        // Read and write from the same requester: read only.
        req_rd = 2'b01;
        req_wr = 2'b01;
        xfer(0, 2, 1'b1);

        // Timeout on requester 0, then requester 1 is next.
        req_rd = 2'b01;
        xfer(TMO_CYC + 5, 1, 1'b0);
        req_rd = 2'b11;
        req_lba[1] = 32'h1111;
        xfer(1, 2, 1'b1);
        req_rd = '0;
        req_wr = '0;
        step();

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            req_rd = NBD'($urandom_range(0, 3));
            req_wr = NBD'($urandom_range(0, 3));
            for (int r = 0; r < NBD; r++) begin
                req_lba[r]      = $urandom;
                req_blk_cnt[r]  = 6'($urandom);
                req_buff_din[r] = 8'($urandom);
            end
            xfer(int'($urandom_range(0, TMO_CYC + 2)), int'($urandom_range(1, 6)),
                 1'($urandom_range(0, 1)));
        end
        req_rd = '0;
        req_wr = '0;
        step();

        // Reset in the middle of a transfer.
        req_lba[0] = 32'h0000_0F00;
        req_lba[1] = 32'h0000_0F01;
        req_rd = 2'b11;
        g = rr(m_last, 2'b11);
        step();
        check("mid_strobe", sd_rd, 1);
        sd_ack = 1'b1;
        step();
        check("mid_ack", req_ack, onehot(g));
        reset = 1'b1;
        step();
        check("mid_rst_ack", req_ack, 0);
        check("mid_rst_rd", sd_rd, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lba", sd_lba, 0);
        reset  = 1'b0;
        sd_ack = 1'b0;
        m_last = NBD - 1;
        xfer(1, 2, 1'b1);
        check("post_rst_grant0", sd_lba, 32'h0000_0F00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
